dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single data-memory BRAM port (12-bit word address, 32-bit data, 4-bit byte write enable, 1-cycle synchronous read) between two requesters.
- Port m0 is the CPU load/store path. Port m1 is the loader/debug master.
- Arbitration is round-robin, with an optional lock for back-to-back bursts. A burst-length cap keeps either requester from starving the other.
- Sits between the cpu load/store datapath and the data memory bram instance.

Parameters:
- ADDR_WIDTH, 12, word address width driven to the memory.
- DATA_WIDTH, 32, data width; byte-enable width is DATA_WIDTH/8.
- MAX_BURST, 8, maximum consecutive locked grants while the other requester waits (range 1..255).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-low.
- m0_req  in  1  m0 access request; held until the cycle it is granted.
- m0_lock  in  1  m0 asks to keep ownership after the current grant.
- m0_addr  in  ADDR_WIDTH  m0 word address.
- m0_we  in  DATA_WIDTH/8  m0 byte write enables; all zero means a read.
- m0_wdata  in  DATA_WIDTH  m0 write data.
- m0_gnt  out  1  m0 access is issued to memory this cycle (combinational).
- m0_rvalid  out  1  read data for m0's previous-cycle read is valid.
- m0_rdata  out  DATA_WIDTH  read data for m0.
- m1_* (req, lock, addr, we, wdata, gnt, rvalid, rdata): identical set for m1.
- mem_addr  out  ADDR_WIDTH  to bram rd_addr/wr_addr.
- mem_byte_w_en  out  DATA_WIDTH/8  to bram byte_w_en.
- mem_wdata  out  DATA_WIDTH  to bram ram_in.
- mem_r_en  out  1  to bram r_en.
- mem_rdata  in  DATA_WIDTH  from bram r_out; valid 1 cycle after the address.
- owner  out  2  current ownership state: 00 IDLE, 01 LOCK0, 10 LOCK1.

Behaviour:
- State: fsm {IDLE, LOCK0, LOCK1}; last (1 bit, last granted requester); burst_cnt (8 bits); rv0, rv1 (rvalid flops).
- Reset (rst=0 at a clock edge):
  - fsm=IDLE, last=1 (so m0 wins first contention), burst_cnt=0, rv0=rv1=0.
  - While rst=0, all gnt, mem_r_en and mem_byte_w_en are forced to 0.
  - Reset mid-read suppresses the pending rvalid.
- Grant is combinational from fsm/last/burst_cnt and the req inputs. At most one gnt per cycle. The granted requester's addr/we/wdata are muxed to mem_* in the same cycle.
- No grant: mem_byte_w_en=0, mem_r_en=0, mem_addr/mem_wdata = m0 values.
- Granted read (we==0): mem_r_en=1.
- Granted write: mem_r_en=0 and mem_byte_w_en=we.
- IDLE:
  - Only one req high: grant it.
  - Both high: grant the requester that is not `last`.
  - On a grant to x: last<=x. If mx_lock=1, fsm<=LOCKx and burst_cnt<=1; otherwise stay IDLE.
- LOCKx, with y the other requester:
  - Other requester stalls (gnt_y=0) unless the cap is hit.
  - If mx_req=1 and (burst_cnt<MAX_BURST or my_req=0): grant x, last<=x, burst_cnt saturating +1.
    - mx_lock=0 on that grant: fsm<=IDLE after it.
  - If mx_req=0 and mx_lock=0: no grant this cycle, fsm<=IDLE.
  - If mx_req=0 and mx_lock=1: bus held idle, no grant.
  - Cap: burst_cnt==MAX_BURST and my_req=1: grant y instead, last<=y, burst_cnt<=1.
    - my_lock=1: fsm<=LOCKy; otherwise fsm<=IDLE.
- Read return:
  - rvx <= gnt_x & (mx_we==0). mx_rvalid=rvx.
  - mx_rdata = rvx ? mem_rdata : 0.
  - Fixed read latency is 1 cycle; there is no backpressure, so requesters must accept rdata in that cycle.
- Write completes in its grant cycle. No rvalid is generated for a write.
- A simultaneous grant of x's read and y's request in the next cycle is legal. Both rvalid flops are never high together.

Test Plan:
- Reset priority: reset, then m0 read addr 0x010 and m1 read addr 0x020 requested together in the first cycle. Expect m0_gnt=1, mem_addr=0x010, next cycle m0_rvalid=1 with bram data. Following cycle m1_gnt=1, mem_addr=0x020.
- Round-robin: both req held continuously with lock=0 for 6 cycles. Expect gnt pattern m0,m1,m0,m1,m0,m1 and owner=00 throughout.
- Write passthrough: m1 writes we=4'b0011, wdata=0xDEADBEEF, addr 0x005. Expect mem_byte_w_en=0011 in the grant cycle and no m1_rvalid. Then m0 reads 0x005 and gets lower half 0xBEEF.
- Lock with starvation cap (MAX_BURST=4): m0_lock=1, m0_req=1 continuously, m1_req=1 from cycle 1. Expect m0 granted 4 times (owner=01), then m1 granted once, then m0 regains.
- Lock release: m1 locked, drops req and lock in the same cycle. Expect no grant that cycle, owner=00 next cycle, and a pending m0 request granted that cycle.
- Reset mid-read: m0 read granted, rst=0 on the following edge. Expect m0_rvalid=0, all gnt=0 while rst=0, owner=00.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-master arbiter for the single data-memory BRAM port: round-robin with
// optional burst lock, starvation cap, and 1-cycle read-return routing.
module dmem_arbiter #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MAX_BURST  = 8
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    m0_req,
    input  logic                    m0_lock,
    input  logic [ADDR_WIDTH-1:0]   m0_addr,
    input  logic [DATA_WIDTH/8-1:0] m0_we,
    input  logic [DATA_WIDTH-1:0]   m0_wdata,
    output logic                    m0_gnt,
    output logic                    m0_rvalid,
    output logic [DATA_WIDTH-1:0]   m0_rdata,

    input  logic                    m1_req,
    input  logic                    m1_lock,
    input  logic [ADDR_WIDTH-1:0]   m1_addr,
    input  logic [DATA_WIDTH/8-1:0] m1_we,
    input  logic [DATA_WIDTH-1:0]   m1_wdata,
    output logic                    m1_gnt,
    output logic                    m1_rvalid,
    output logic [DATA_WIDTH-1:0]   m1_rdata,

    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH/8-1:0] mem_byte_w_en,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic                    mem_r_en,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,

    output logic [1:0]              owner
);

    localparam logic [7:0] CAP = 8'(MAX_BURST);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        LOCK0 = 2'b01,
        LOCK1 = 2'b10
    } state_t;

    state_t     fsm, fsm_nxt;
    logic       last, last_nxt;
    logic [7:0] burst_cnt, burst_cnt_nxt;
    logic       rv0, rv1;
    logic       gnt0, gnt1;

    always_comb begin
        fsm_nxt       = fsm;
        last_nxt      = last;
        burst_cnt_nxt = burst_cnt;
        gnt0          = 1'b0;
        gnt1          = 1'b0;
        case (fsm)
            IDLE: begin
                if (m0_req && (!m1_req || last)) begin
                    gnt0     = 1'b1;
                    last_nxt = 1'b0;
                    if (m0_lock) begin
                        fsm_nxt       = LOCK0;
                        burst_cnt_nxt = 8'd1;
                    end
                end else if (m1_req) begin
                    gnt1     = 1'b1;
                    last_nxt = 1'b1;
                    if (m1_lock) begin
                        fsm_nxt       = LOCK1;
                        burst_cnt_nxt = 8'd1;
                    end
                end
            end
            LOCK0: begin
                if (m0_req && (burst_cnt < CAP || !m1_req)) begin
                    gnt0     = 1'b1;
                    last_nxt = 1'b0;
                    if (burst_cnt != 8'hFF) burst_cnt_nxt = burst_cnt + 8'd1;
                    if (!m0_lock) fsm_nxt = IDLE;
                end else if (burst_cnt >= CAP && m1_req) begin
                    gnt1          = 1'b1;
                    last_nxt      = 1'b1;
                    burst_cnt_nxt = 8'd1;
                    fsm_nxt       = m1_lock ? LOCK1 : IDLE;
                end else if (!m0_lock) begin
                    fsm_nxt = IDLE;
                end
            end
            LOCK1: begin
                if (m1_req && (burst_cnt < CAP || !m0_req)) begin
                    gnt1     = 1'b1;
                    last_nxt = 1'b1;
                    if (burst_cnt != 8'hFF) burst_cnt_nxt = burst_cnt + 8'd1;
                    if (!m1_lock) fsm_nxt = IDLE;
                end else if (burst_cnt >= CAP && m0_req) begin
                    gnt0          = 1'b1;
                    last_nxt      = 1'b0;
                    burst_cnt_nxt = 8'd1;
                    fsm_nxt       = m0_lock ? LOCK0 : IDLE;
                end else if (!m1_lock) begin
                    fsm_nxt = IDLE;
                end
            end
            default: fsm_nxt = IDLE;
        endcase
        // Grants are suppressed for the whole reset cycle, not just after the edge.
        if (!rst) begin
            gnt0 = 1'b0;
            gnt1 = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            fsm       <= IDLE;
            last      <= 1'b1;
            burst_cnt <= '0;
            rv0       <= 1'b0;
            rv1       <= 1'b0;
        end else begin
            fsm       <= fsm_nxt;
            last      <= last_nxt;
            burst_cnt <= burst_cnt_nxt;
            rv0       <= gnt0 && (m0_we == '0);
            rv1       <= gnt1 && (m1_we == '0);
        end
    end

    assign m0_gnt        = gnt0;
    assign m1_gnt        = gnt1;
    assign mem_addr      = gnt1 ? m1_addr  : m0_addr;
    assign mem_wdata     = gnt1 ? m1_wdata : m0_wdata;
    assign mem_byte_w_en = gnt0 ? m0_we : (gnt1 ? m1_we : '0);
    assign mem_r_en      = (gnt0 && (m0_we == '0)) || (gnt1 && (m1_we == '0));

    assign m0_rvalid = rv0;
    assign m1_rvalid = rv1;
    assign m0_rdata  = rv0 ? mem_rdata : '0;
    assign m1_rdata  = rv1 ? mem_rdata : '0;
    assign owner     = fsm;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed vector table plus randomized traffic
// checked against a per-cycle arbitration model and a shadow memory.
module tb_dmem_arbiter;

    localparam int MAXB = 4;

    logic        clk;
    logic        rst;
    logic        m0_req, m0_lock, m1_req, m1_lock;
    logic [11:0] m0_addr, m1_addr, mem_addr;
    logic [3:0]  m0_we, m1_we, mem_byte_w_en;
    logic [31:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata, mem_wdata, mem_rdata;
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_r_en;
    logic [1:0]  owner;

    dmem_arbiter #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .MAX_BURST(MAXB)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_we(m0_we),
        .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_we(m1_we),
        .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_addr(mem_addr), .mem_byte_w_en(mem_byte_w_en), .mem_wdata(mem_wdata),
        .mem_r_en(mem_r_en), .mem_rdata(mem_rdata), .owner(owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input logic [11:0] a);
        return (32'(a) * 32'h9E3779B1) ^ 32'h00C0FFEE;
    endfunction

    // BRAM stand-in: untouched words read back as init_word(addr).
    logic [31:0] bram [4096];
    bit          bw   [4096];
    initial mem_rdata = '0;
    always @(posedge clk) begin : bram_model
        logic [31:0] cur;
        if (mem_r_en) mem_rdata <= bw[mem_addr] ? bram[mem_addr] : init_word(mem_addr);
        if (|mem_byte_w_en) begin
            cur = bw[mem_addr] ? bram[mem_addr] : init_word(mem_addr);
            for (int b = 0; b < 4; b++)
                if (mem_byte_w_en[b]) cur[8*b +: 8] = mem_wdata[8*b +: 8];
            bram[mem_addr] <= cur;
            bw[mem_addr]   <= 1'b1;
        end
    end

    typedef struct {
        logic        rst;
        logic        r0, l0; logic [11:0] a0; logic [3:0] w0; logic [31:0] d0;
        logic        r1, l1; logic [11:0] a1; logic [3:0] w1; logic [31:0] d1;
        logic [1:0]  egnt;   // {m1_gnt, m0_gnt}
        logic [1:0]  eown;
        logic [11:0] eaddr;
        logic        chk_rd;
        logic [15:0] erd;
    } vec_t;

    function automatic vec_t mk(input logic rs,
        input logic r0, input logic l0, input logic [11:0] a0, input logic [3:0] w0, input logic [31:0] d0,
        input logic r1, input logic l1, input logic [11:0] a1, input logic [3:0] w1, input logic [31:0] d1,
        input logic [1:0] eg, input logic [1:0] eo, input logic [11:0] ea);
        vec_t v;
        v.rst = rs;
        v.r0 = r0; v.l0 = l0; v.a0 = a0; v.w0 = w0; v.d0 = d0;
        v.r1 = r1; v.l1 = l1; v.a1 = a1; v.w1 = w1; v.d1 = d1;
        v.egnt = eg; v.eown = eo; v.eaddr = ea; v.chk_rd = 1'b0; v.erd = '0;
        return v;
    endfunction

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference state: owner -1 = nobody, else requester index.
    int          m_own, m_last, m_cnt;
    bit          m_rv   [2];
    logic [31:0] m_rexp [2];
    logic [31:0] shadow [4096];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_own = -1; m_last = 1; m_cnt = 0;
        m_rv[0] = 0; m_rv[1] = 0;
    endtask

    task automatic step(input vec_t v, input bit use_tbl, input bit mid_rst);
        int          g, nown, nlast, ncnt, x, y;
        bit          req [2], lck [2], cap, rvn [2];
        logic [11:0] ad  [2];
        logic [3:0]  we  [2];
        logic [31:0] wd  [2];
        logic [1:0]  eo;
        @(negedge clk);
        rst = v.rst;
        m0_req = v.r0; m0_lock = v.l0; m0_addr = v.a0; m0_we = v.w0; m0_wdata = v.d0;
        m1_req = v.r1; m1_lock = v.l1; m1_addr = v.a1; m1_we = v.w1; m1_wdata = v.d1;
        #1;
        cyc++;
        req[0] = v.r0; lck[0] = v.l0; ad[0] = v.a0; we[0] = v.w0; wd[0] = v.d0;
        req[1] = v.r1; lck[1] = v.l1; ad[1] = v.a1; we[1] = v.w1; wd[1] = v.d1;
        g = -1; nown = m_own; nlast = m_last; ncnt = m_cnt;
        if (v.rst) begin
            if (m_own < 0) begin
                if (req[0] && req[1]) g = 1 - m_last;
                else if (req[0])      g = 0;
                else if (req[1])      g = 1;
                if (g >= 0) begin
                    nlast = g;
                    if (lck[g]) begin nown = g; ncnt = 1; end
                end
            end else begin
                x = m_own; y = 1 - m_own;
                cap = (m_cnt >= MAXB) && req[y];
                if (req[x] && !cap) begin
                    g = x; nlast = x; ncnt = (m_cnt < 255) ? m_cnt + 1 : 255;
                    if (!lck[x]) nown = -1;
                end else if (cap) begin
                    g = y; nlast = y; ncnt = 1;
                    nown = lck[y] ? y : -1;
                end else if (!lck[x]) begin
                    nown = -1;
                end
            end
        end
        eo = (m_own < 0) ? 2'b00 : ((m_own == 0) ? 2'b01 : 2'b10);

        chk("owner",     owner,         eo);
        chk("m0_gnt",    m0_gnt,        g == 0);
        chk("m1_gnt",    m1_gnt,        g == 1);
        chk("mem_addr",  mem_addr,      (g == 1) ? ad[1] : ad[0]);
        chk("mem_wdata", mem_wdata,     (g == 1) ? wd[1] : wd[0]);
        chk("mem_be",    mem_byte_w_en, (g >= 0) ? we[g] : 4'h0);
        chk("mem_r_en",  mem_r_en,      (g >= 0) && (we[g] == 4'h0));
        chk("m0_rvalid", m0_rvalid,     m_rv[0]);
        chk("m1_rvalid", m1_rvalid,     m_rv[1]);
        chk("m0_rdata",  m0_rdata,      m_rv[0] ? m_rexp[0] : 32'h0);
        chk("m1_rdata",  m1_rdata,      m_rv[1] ? m_rexp[1] : 32'h0);
        if (use_tbl) begin
            chk("tbl_gnt",   {m1_gnt, m0_gnt}, v.egnt);
            chk("tbl_owner", owner,            v.eown);
            chk("tbl_addr",  mem_addr,         v.eaddr);
            if (v.chk_rd) chk("tbl_rdata_lo", m0_rdata[15:0], v.erd);
        end

        rvn[0] = 0; rvn[1] = 0;
        if (g >= 0 && !mid_rst) begin
            if (we[g] == 4'h0) begin
                rvn[g] = 1;
                m_rexp[g] = shadow[ad[g]];
            end else begin
                for (int b = 0; b < 4; b++)
                    if (we[g][b]) shadow[ad[g]][8*b +: 8] = wd[g][8*b +: 8];
            end
        end
        if (!v.rst || mid_rst) begin
            model_reset();
        end else begin
            m_own = nown; m_last = nlast; m_cnt = ncnt;
            m_rv[0] = rvn[0]; m_rv[1] = rvn[1];
        end
        if (mid_rst) begin
            #1 rst = 1'b0;
        end
    endtask

    vec_t tbl [$];
    vec_t v;

    initial begin
        for (int i = 0; i < 4096; i++) shadow[i] = init_word(12'(i));
        rst = 1'b0;
        m0_req = 0; m0_lock = 0; m0_addr = '0; m0_we = '0; m0_wdata = '0;
        m1_req = 0; m1_lock = 0; m1_addr = '0; m1_we = '0; m1_wdata = '0;
        model_reset();
        repeat (2) @(posedge clk);

        // reset state, then first-contention priority
        tbl.push_back(mk(0, 1,0,12'h010,4'h0,0, 1,0,12'h020,4'h0,0, 2'b00,2'b00,12'h010));
        tbl.push_back(mk(1, 1,0,12'h010,4'h0,0, 1,0,12'h020,4'h0,0, 2'b01,2'b00,12'h010));
        tbl.push_back(mk(1, 0,0,12'h010,4'h0,0, 1,0,12'h020,4'h0,0, 2'b10,2'b00,12'h020));
        // round robin
        for (int i = 0; i < 6; i++)
            tbl.push_back(mk(1, 1,0,12'h030,4'h0,0, 1,0,12'h040,4'h0,0,
                             (i % 2 == 0) ? 2'b01 : 2'b10, 2'b00, (i % 2 == 0) ? 12'h030 : 12'h040));
        // write passthrough then read back
        tbl.push_back(mk(1, 0,0,12'h000,4'h0,0, 1,0,12'h005,4'b0011,32'hDEADBEEF, 2'b10,2'b00,12'h005));
        tbl.push_back(mk(1, 1,0,12'h005,4'h0,0, 0,0,12'h005,4'h0,0, 2'b01,2'b00,12'h005));
        v = mk(1, 0,0,12'h000,4'h0,0, 0,0,12'h000,4'h0,0, 2'b00,2'b00,12'h000);
        v.chk_rd = 1'b1; v.erd = 16'hBEEF;
        tbl.push_back(v);
        // lock with starvation cap
        tbl.push_back(mk(1, 1,1,12'h100,4'h0,0, 0,0,12'h200,4'h0,0, 2'b01,2'b00,12'h100));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(1, 1,1,12'h100,4'h0,0, 1,0,12'h200,4'h0,0, 2'b01,2'b01,12'h100));
        tbl.push_back(mk(1, 1,1,12'h100,4'h0,0, 1,0,12'h200,4'h0,0, 2'b10,2'b01,12'h200));
        tbl.push_back(mk(1, 1,1,12'h100,4'h0,0, 1,0,12'h200,4'h0,0, 2'b01,2'b00,12'h100));
        tbl.push_back(mk(1, 0,0,12'h100,4'h0,0, 0,0,12'h200,4'h0,0, 2'b00,2'b01,12'h100));
        // m1 lock then release with m0 pending
        tbl.push_back(mk(1, 0,0,12'h110,4'h0,0, 1,1,12'h210,4'h0,0, 2'b10,2'b00,12'h210));
        tbl.push_back(mk(1, 1,0,12'h110,4'h0,0, 1,1,12'h210,4'h0,0, 2'b10,2'b10,12'h210));
        tbl.push_back(mk(1, 1,0,12'h110,4'h0,0, 0,0,12'h210,4'h0,0, 2'b00,2'b10,12'h110));
        tbl.push_back(mk(1, 1,0,12'h110,4'h0,0, 0,0,12'h210,4'h0,0, 2'b01,2'b00,12'h110));
        // reset on the edge after a read grant
        tbl.push_back(mk(1, 1,0,12'h300,4'h0,0, 0,0,12'h301,4'h0,0, 2'b01,2'b00,12'h300));
        tbl.push_back(mk(0, 1,0,12'h300,4'h0,0, 1,0,12'h301,4'h0,0, 2'b00,2'b00,12'h300));
        tbl.push_back(mk(0, 1,0,12'h300,4'h0,0, 1,0,12'h301,4'h0,0, 2'b00,2'b00,12'h300));
        tbl.push_back(mk(1, 1,0,12'h310,4'h0,0, 1,0,12'h320,4'h0,0, 2'b01,2'b00,12'h310));
        // lock held with no request keeps the bus idle
        tbl.push_back(mk(1, 0,0,12'h310,4'h0,0, 1,1,12'h330,4'h0,0, 2'b10,2'b00,12'h330));
        tbl.push_back(mk(1, 1,0,12'h310,4'h0,0, 0,1,12'h330,4'h0,0, 2'b00,2'b10,12'h310));
        tbl.push_back(mk(1, 1,0,12'h310,4'h0,0, 0,0,12'h330,4'h0,0, 2'b00,2'b10,12'h310));
        tbl.push_back(mk(1, 1,0,12'h310,4'h0,0, 0,0,12'h330,4'h0,0, 2'b01,2'b00,12'h310));

        foreach (tbl[i]) step(tbl[i], 1'b1, 1'b0);

        // reset asserted within the read-grant cycle, ahead of the edge
        step(mk(1, 1,0,12'h040,4'h0,0, 0,0,12'h000,4'h0,0, 2'b01,2'b00,12'h040), 1'b1, 1'b1);
        step(mk(0, 0,0,12'h000,4'h0,0, 0,0,12'h000,4'h0,0, 2'b00,2'b00,12'h000), 1'b1, 1'b0);
        chk("midrst_rvalid", m0_rvalid, 1'b0);
        step(mk(1, 0,0,12'h000,4'h0,0, 0,0,12'h000,4'h0,0, 2'b00,2'b00,12'h000), 1'b1, 1'b0);

        for (int i = 0; i < 4000; i++) begin
            v = mk(1, 0,0,12'h000,4'h0,0, 0,0,12'h000,4'h0,0, 2'b00,2'b00,12'h000);
            v.rst = ($urandom_range(0, 59) != 0);
            v.r0  = ($urandom_range(0, 3) != 0);
            v.l0  = ($urandom_range(0, 2) == 0);
            v.a0  = 12'($urandom_range(0, 15));
            v.w0  = ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0;
            v.d0  = $urandom;
            v.r1  = ($urandom_range(0, 3) != 0);
            v.l1  = ($urandom_range(0, 2) == 0);
            v.a1  = 12'($urandom_range(0, 15));
            v.w1  = ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0;
            v.d1  = $urandom;
            step(v, 1'b0, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
